hex_word_ascii_tx: RTL and testbench
====================================

# hex_word_ascii_tx

Streams a DATA_W-bit binary word as printable ASCII hexadecimal characters, one byte per handshake, for the UART transmit path. It accepts a word on a valid/ready input and emits the characters MSB-nibble first on a valid/ready byte output that feeds the UART TX byte interface. Per word, it can optionally emit a "0x" prefix, suppress leading zeros, select lowercase digits, and append a CR LF terminator.

## Interface
- DATA_W, 32: input word width; must be a multiple of 4 and ≥4; any other value is an elaboration error.
- PREFIX_EN, 1: emit "0x" (0x30, 0x78) before the digits.
- TERM_EN, 1: emit CR LF (0x0D, 0x0A) after the digits.
- clk  in  1  single clock; all logic is rising-edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  in_data and mode bits are valid.
- in_ready  out  1  high only in IDLE; the word is accepted on in_valid&&in_ready.
- in_data  in  DATA_W  word to print.
- in_lower  in  1  1 = digits a-f (0x61-0x66); 0 = A-F (0x41-0x46). Sampled at accept.
- in_suppress_lz  in  1  1 = skip leading zero nibbles. Sampled at accept.
- out_valid  out  1  out_char is valid.
- out_ready  in  1  the UART TX consumes the byte on out_valid&&out_ready.
- out_char  out  8  ASCII byte.
- out_last  out  1  marks the final byte of the current word.
- busy  out  1  high from accept until the last byte handshake.

## Operation
- FSM states: IDLE, PFX0, PFX1, DIGIT, CR, LF.
- IDLE:
  - in_ready=1 and out_valid=0.
  - On accept, register in_data, in_lower and the start nibble index.
  - Next state is PFX0 if PREFIX_EN, else DIGIT.
- Start nibble index:
  - With suppression off: NIB-1, where NIB=DATA_W/4.
  - With suppression on: index of the most significant nonzero nibble, found by a priority encoder at accept. An all-zero word gives index 0, so one '0' is always printed.
- Byte per state:
  - PFX0 outputs 0x30; PFX1 outputs 0x78 ('x' is always lowercase).
  - DIGIT outputs the ASCII of nibble[idx], then decrements idx. It leaves DIGIT after idx=0 is consumed.
  - CR outputs 0x0D; LF outputs 0x0A.
- States advance only on out_valid&&out_ready. The state after DIGIT is CR if TERM_EN, else IDLE.
- out_last=1 on the final byte: LF if TERM_EN, else digit idx=0.
- Nibble-to-ASCII mapping: 0-9 → 0x30-0x39; 10-15 → 0x41-0x46, or 0x61-0x66 when lower is set.
- Index counter width: max(1, $clog2(NIB)). It never wraps below 0; the transition at idx=0 is the exit.
- Backpressure: out_char, out_last and the state are held while out_valid && !out_ready.
- in_valid during busy is ignored (in_ready=0), and the held word is unaffected.
- Reset (async, any time): state=IDLE; out_valid=0, out_char=0x00, out_last=0, busy=0; in_ready=1 (combinational from IDLE). A word in flight is discarded and no partial terminator is emitted.

## Timing
- Accept at edge k: out_valid=1 with the first byte from cycle k+1. There is no combinational path from in_valid to out_valid.
- With out_ready held at 1, one byte is transferred per cycle and no bubbles occur inside a word.
- Last-byte handshake at edge m: in_ready=1 during cycle m+1, and the next accept is possible at edge m+1.
- Word period = bytes+1 cycles. Full 32-bit word with prefix and terminator: 12 bytes, 13 cycles.
- Byte count = PREFIX_EN*2 + digits + TERM_EN*2, where digits ranges 1..NIB.
- out_ready is registered-path safe: out_char is a registered output, and out_ready only gates the state advance.

## Structure
- Package hex_ascii_pkg holds:
  - the state enum;
  - constants ASCII_0, ASCII_X, ASCII_CR, ASCII_LF, ASCII_UC_A and ASCII_LC_A;
  - the function nibble_to_ascii(nib, lower).
- One sub-module, hex_nibble_ascii: combinational, 4-bit + lower in, 8-bit out. The parametrised successor of the single-nibble converter, instantiated once on the selected nibble.
- The leading-zero priority encoder stays in the top level as a generate loop over NIB.

## Test plan
- DATA_W=32, defaults, in_data=0x00A51F3C, lower=0, lz=0, out_ready=1 → bytes 30 78 30 30 41 35 31 46 33 43 0D 0A on 12 consecutive cycles; out_last only on 0A; in_ready returns 13 cycles after accept.
- Same word with lz=1 → 30 78 41 35 31 46 33 43 0D 0A. in_data=0x00000000 with lz=1 → 30 78 30 0D 0A.
- in_data=0xDEADBEEF, lower=1 → 30 78 64 65 61 64 62 65 65 66 0D 0A. Then immediately 0xDEADBEEF with lower=0 → digits 44 45 41 44 42 45 45 46, accepted at the first IDLE cycle.
- Random out_ready (50%) over 200 random words: each byte is stable while stalled, no byte is lost or duplicated, and a scoreboard matches a reference formatter. in_valid toggling during busy has no effect.
- rst_n pulsed low mid-DIGIT: out_valid drops asynchronously and in_ready=1. The next word prints from PFX0 in full.
- Elaboration sweep: DATA_W=4, PREFIX_EN=0, TERM_EN=0, in_data=0x7 → single byte 0x37 with out_last=1. DATA_W=8 with TERM_EN only, 0xF0 → 46 30 0D 0A.

Source files
------------

// File: rtl/hex_ascii_pkg.sv
// Shared types, ASCII constants and the nibble-to-character mapping
// used by the hex word transmitter.
package hex_ascii_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    PFX0  = 3'd1,
    PFX1  = 3'd2,
    DIGIT = 3'd3,
    CR    = 3'd4,
    LF    = 3'd5
  } state_t;

  localparam logic [7:0] ASCII_0    = 8'h30;
  localparam logic [7:0] ASCII_X    = 8'h78;
  localparam logic [7:0] ASCII_CR   = 8'h0D;
  localparam logic [7:0] ASCII_LF   = 8'h0A;
  localparam logic [7:0] ASCII_UC_A = 8'h41;
  localparam logic [7:0] ASCII_LC_A = 8'h61;

  function automatic logic [7:0] nibble_to_ascii(input logic [3:0] nib, input logic lower);
    if (nib < 4'd10) return ASCII_0 + {4'd0, nib};
    return (lower ? ASCII_LC_A : ASCII_UC_A) + {4'd0, nib} - 8'd10;
  endfunction

endpackage

// File: rtl/hex_nibble_ascii.sv
// Combinational converter from one 4-bit nibble to its ASCII hex digit.
module hex_nibble_ascii
  import hex_ascii_pkg::*;
(
  input  logic [3:0] nib_i,
  input  logic       lower_i,
  output logic [7:0] char_o
);

  assign char_o = nibble_to_ascii(nib_i, lower_i);

endmodule

// File: rtl/hex_word_ascii_tx.sv
// Streams a binary word as ASCII hex characters over a valid/ready byte
// interface, with optional "0x" prefix, leading-zero suppression and CR LF.
module hex_word_ascii_tx
  import hex_ascii_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter bit PREFIX_EN = 1'b1,
  parameter bit TERM_EN   = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_lower,
  input  logic              in_suppress_lz,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [7:0]        out_char,
  output logic              out_last,
  output logic              busy
);

  localparam int NIB   = DATA_W / 4;
  localparam int IDX_W = (NIB > 1) ? $clog2(NIB) : 1;

  if ((DATA_W % 4) != 0 || DATA_W < 4) begin : g_bad_width
    $error("hex_word_ascii_tx: DATA_W must be a multiple of 4 and at least 4");
  end

  state_t             state_q, state_d;
  logic [DATA_W-1:0]  data_q, data_d;
  logic               lower_q, lower_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               out_valid_q;
  logic [7:0]         out_char_q, char_d;
  logic               out_last_q, last_d;
  logic [IDX_W-1:0]   lz_idx, start_idx;
  logic [3:0]         sel_nib;
  logic [7:0]         digit_char;
  logic               fire;

  // Priority chain: each stage overrides the lower ones when its nibble is nonzero.
  for (genvar gi = 0; gi < NIB; gi++) begin : g_lz
    logic [IDX_W-1:0] sel;
    if (gi == 0) begin : g_first
      assign sel = '0;
    end else begin : g_rest
      assign sel = (|in_data[gi*4 +: 4]) ? IDX_W'(gi) : g_lz[gi-1].sel;
    end
  end

  assign lz_idx    = g_lz[NIB-1].sel;
  assign start_idx = in_suppress_lz ? lz_idx : IDX_W'(NIB - 1);
  assign fire      = out_valid_q && out_ready;

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    lower_d = lower_q;
    idx_d   = idx_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          data_d  = in_data;
          lower_d = in_lower;
          idx_d   = start_idx;
          state_d = PREFIX_EN ? PFX0 : DIGIT;
        end
      end
      PFX0:  if (fire) state_d = PFX1;
      PFX1:  if (fire) state_d = DIGIT;
      DIGIT: begin
        if (fire) begin
          if (idx_q == '0) state_d = TERM_EN ? CR : IDLE;
          else             idx_d   = idx_q - 1'b1;
        end
      end
      CR:      if (fire) state_d = LF;
      LF:      if (fire) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // The output byte is precomputed from the next state so out_char stays registered.
  assign sel_nib = 4'(data_d >> {idx_d, 2'b00});

  hex_nibble_ascii u_nib (
    .nib_i   (sel_nib),
    .lower_i (lower_d),
    .char_o  (digit_char)
  );

  always_comb begin
    char_d = 8'h00;
    last_d = 1'b0;
    case (state_d)
      PFX0:  char_d = ASCII_0;
      PFX1:  char_d = ASCII_X;
      DIGIT: begin
        char_d = digit_char;
        last_d = !TERM_EN && (idx_d == '0);
      end
      CR:    char_d = ASCII_CR;
      LF: begin
        char_d = ASCII_LF;
        last_d = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      data_q      <= '0;
      lower_q     <= 1'b0;
      idx_q       <= '0;
      out_valid_q <= 1'b0;
      out_char_q  <= 8'h00;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      data_q      <= data_d;
      lower_q     <= lower_d;
      idx_q       <= idx_d;
      out_valid_q <= (state_d != IDLE);
      out_char_q  <= char_d;
      out_last_q  <= last_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign out_valid = out_valid_q;
  assign out_char  = out_char_q;
  assign out_last  = out_last_q;

endmodule

// File: tb/tb_hex_word_ascii_tx.sv
// Directed and randomised checks of hex_word_ascii_tx, plus two small
// parameter variants (4-bit bare, 8-bit terminator only).
module tb_hex_word_ascii_tx;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, in_lower, in_suppress_lz;
  logic [31:0] in_data;
  logic        out_valid, out_ready, out_last, busy;
  logic [7:0]  out_char;

  logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_out_last, a_busy;
  logic [3:0]  a_in_data;
  logic [7:0]  a_out_char;
  logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_last, b_busy;
  logic [7:0]  b_in_data;
  logic [7:0]  b_out_char;

  int errors = 0;
  int checks = 0;
  int wn, cy;
  logic [7:0]  exp_q[$];
  logic [31:0] rd;

  always #5 clk = ~clk;

  hex_word_ascii_tx #(.DATA_W(32), .PREFIX_EN(1'b1), .TERM_EN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_lower(in_lower), .in_suppress_lz(in_suppress_lz),
    .out_valid(out_valid), .out_ready(out_ready), .out_char(out_char),
    .out_last(out_last), .busy(busy)
  );

  hex_word_ascii_tx #(.DATA_W(4), .PREFIX_EN(1'b0), .TERM_EN(1'b0)) u4 (
    .clk(clk), .rst_n(rst_n), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .in_data(a_in_data), .in_lower(1'b0), .in_suppress_lz(1'b0),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_char(a_out_char),
    .out_last(a_out_last), .busy(a_busy)
  );

  hex_word_ascii_tx #(.DATA_W(8), .PREFIX_EN(1'b0), .TERM_EN(1'b1)) u8 (
    .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_data(b_in_data), .in_lower(1'b0), .in_suppress_lz(1'b0),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_char(b_out_char),
    .out_last(b_out_last), .busy(b_busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference formatter for the 32-bit instance with prefix and terminator.
  task automatic build_exp(input logic [31:0] d, input bit lower, input bit lz);
    int top;
    logic [7:0] n;
    exp_q.delete();
    exp_q.push_back(8'h30);
    exp_q.push_back(8'h78);
    top = 7;
    if (lz) begin
      top = 0;
      for (int i = 0; i < 8; i++) if (((d >> (i * 4)) & 32'hF) != 0) top = i;
    end
    for (int i = top; i >= 0; i--) begin
      n = 8'((d >> (i * 4)) & 32'hF);
      if (n < 8'd10) exp_q.push_back(8'h30 + n);
      else           exp_q.push_back((lower ? 8'h61 : 8'h41) + n - 8'd10);
    end
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
  endtask

  // Caller must be just after a negedge. Offers a word, then drains exp_q with
  // out_ready high pct% of the time, checking every presented byte.
  task automatic run_word(input string tag, input logic [31:0] d, input bit lower,
                          input bit lz, input int pct, input bit toggle,
                          output int wait_n, output int cyc);
    int k;
    in_data = d; in_lower = lower; in_suppress_lz = lz; in_valid = 1'b1;
    wait_n = 0;
    #1;
    while (!in_ready && wait_n < 200) begin
      @(negedge clk); wait_n++; #1;
    end
    chk({tag, "_accept"}, 32'(in_ready), 32'd1);
    @(negedge clk);
    in_valid = toggle ? 1'($urandom) : 1'b0;
    if (toggle) in_data = $urandom;
    cyc = 1;
    k = 0;
    while (k < exp_q.size() && cyc < 400) begin
      out_ready = ($urandom_range(99) < pct);
      #1;
      chk($sformatf("%s_b%0d", tag, k), {22'd0, out_valid, out_last, out_char},
          {22'd0, 1'b1, (k == exp_q.size() - 1), exp_q[k]});
      if (out_ready) k++;
      @(negedge clk);
      cyc++;
      if (toggle && k < exp_q.size()) begin
        in_valid = 1'($urandom);
        in_data  = $urandom;
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    chk({tag, "_count"}, 32'(k), 32'(exp_q.size()));
    #1;
    chk({tag, "_idle"}, {30'd0, in_ready, out_valid}, {30'd0, 1'b1, 1'b0});
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0; in_data = '0; in_lower = 1'b0; in_suppress_lz = 1'b0; out_ready = 1'b1;
    a_in_valid = 1'b0; a_in_data = '0; a_out_ready = 1'b1;
    b_in_valid = 1'b0; b_in_data = '0; b_out_ready = 1'b1;
    #3;
    chk("rst_main", {27'd0, in_ready, out_valid, out_last, busy, 1'b0}, {27'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0});
    chk("rst_char", 32'(out_char), 32'h00);
    chk("rst_small", {28'd0, a_in_ready, a_busy, b_in_ready, b_busy}, {28'd0, 1'b1, 1'b0, 1'b1, 1'b0});
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    exp_q = '{8'h30, 8'h78, 8'h30, 8'h30, 8'h41, 8'h35, 8'h31, 8'h46, 8'h33, 8'h43, 8'h0D, 8'h0A};
    run_word("a51f3c", 32'h00A51F3C, 1'b0, 1'b0, 100, 1'b0, wn, cy);
    chk("a51f3c_period", 32'(cy), 32'd13);

    exp_q = '{8'h30, 8'h78, 8'h41, 8'h35, 8'h31, 8'h46, 8'h33, 8'h43, 8'h0D, 8'h0A};
    run_word("a51f3c_lz", 32'h00A51F3C, 1'b0, 1'b1, 100, 1'b0, wn, cy);
    chk("a51f3c_lz_period", 32'(cy), 32'd11);

    exp_q = '{8'h30, 8'h78, 8'h30, 8'h0D, 8'h0A};
    run_word("zero_lz", 32'h0, 1'b0, 1'b1, 100, 1'b0, wn, cy);

    exp_q = '{8'h30, 8'h78, 8'h64, 8'h65, 8'h61, 8'h64, 8'h62, 8'h65, 8'h65, 8'h66, 8'h0D, 8'h0A};
    run_word("dead_lc", 32'hDEADBEEF, 1'b1, 1'b0, 100, 1'b0, wn, cy);
    exp_q = '{8'h30, 8'h78, 8'h44, 8'h45, 8'h41, 8'h44, 8'h42, 8'h45, 8'h45, 8'h46, 8'h0D, 8'h0A};
    run_word("dead_uc", 32'hDEADBEEF, 1'b0, 1'b0, 100, 1'b0, wn, cy);
    chk("dead_uc_b2b_wait", 32'(wn), 32'd0);

    for (int w = 0; w < 200; w++) begin
      rd = $urandom;
      if ($urandom_range(3) == 0) rd = rd >> $urandom_range(31);
      in_lower = 1'($urandom);
      in_suppress_lz = 1'($urandom);
      build_exp(rd, in_lower, in_suppress_lz);
      run_word($sformatf("rnd%0d", w), rd, in_lower, in_suppress_lz, 50, 1'b1, wn, cy);
    end

    // Asynchronous reset in the middle of the digits, then a clean full word.
    in_data = 32'h00A51F3C; in_lower = 1'b0; in_suppress_lz = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    #1;
    chk("mid_accept", 32'(in_ready), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("mid_pre", {23'd0, out_valid, out_char}, {23'd0, 1'b1, 8'h30});
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst", {27'd0, out_valid, in_ready, busy, out_last, 1'b0}, {27'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0});
    chk("mid_rst_char", 32'(out_char), 32'h00);
    @(negedge clk);
    rst_n = 1'b1;
    exp_q = '{8'h30, 8'h78, 8'h30, 8'h30, 8'h41, 8'h35, 8'h31, 8'h46, 8'h33, 8'h43, 8'h0D, 8'h0A};
    run_word("post_rst", 32'h00A51F3C, 1'b0, 1'b0, 100, 1'b0, wn, cy);

    // DATA_W=4, no prefix or terminator: 0x7 -> '7' flagged last.
    a_in_data = 4'h7; a_in_valid = 1'b1;
    #1;
    chk("w4_accept", 32'(a_in_ready), 32'd1);
    @(negedge clk);
    a_in_valid = 1'b0;
    #1;
    chk("w4_byte", {22'd0, a_out_valid, a_out_last, a_out_char}, {22'd0, 1'b1, 1'b1, 8'h37});
    @(negedge clk);
    #1;
    chk("w4_idle", {30'd0, a_in_ready, a_out_valid}, {30'd0, 1'b1, 1'b0});

    // DATA_W=8, terminator only: 0xF0 -> "F0\r\n".
    exp_q = '{8'h46, 8'h30, 8'h0D, 8'h0A};
    b_in_data = 8'hF0; b_in_valid = 1'b1;
    #1;
    chk("w8_accept", 32'(b_in_ready), 32'd1);
    @(negedge clk);
    b_in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk($sformatf("w8_b%0d", i), {22'd0, b_out_valid, b_out_last, b_out_char},
          {22'd0, 1'b1, (i == 3), exp_q[i]});
      @(negedge clk);
    end
    #1;
    chk("w8_idle", {30'd0, b_in_ready, b_out_valid}, {30'd0, 1'b1, 1'b0});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
